// File: rtl/unidad_de_control_multiciclo.sv
// Multicycle control unit for the MIPS-subset datapath: walks each instruction through
// fetch/decode/execute/memory/writeback and guards memory handshakes with a wait timeout.
module unidad_de_control_multiciclo #(
  parameter int OP_W         = 6,
  parameter int ALUOP_W      = 3,
  parameter int MEM_TIMEOUT  = 15,
  parameter int TRAP_ILLEGAL = 1
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [OP_W-1:0]    op_i,
  input  logic               zero_i,
  input  logic               mem_ready_i,
  output logic               mem_req_o,
  output logic               MemToWrite_o,
  output logic               MemToReg_o,
  output logic               RegWrite_o,
  output logic [ALUOP_W-1:0] ALUOp_o,
  output logic               alu_src_o,
  output logic               reg_dst_o,
  output logic               ir_write_o,
  output logic               pc_write_o,
  output logic               pc_branch_o,
  output logic               instr_done_o,
  output logic               illegal_op_o,
  output logic               halted_o,
  output logic               fault_o
);

  localparam logic [OP_W-1:0] OP_R    = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_ORI  = OP_W'(6'b001101);

  localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(3'b000);
  localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(3'b001);
  localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(3'b010);
  localparam logic [ALUOP_W-1:0] ALU_OR    = ALUOP_W'(3'b011);

  // A zero timeout disables the guard; keep the counter at least one bit wide.
  localparam int              CNT_W    = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (MEM_TIMEOUT > 0) ? CNT_W'(MEM_TIMEOUT - 1) : '0;
  localparam bit              TO_EN    = (MEM_TIMEOUT > 0);

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_ADDR,
    S_MEM_RD,
    S_MEM_WR,
    S_WB,
    S_BRANCH,
    S_HALT
  } state_t;

  state_t           state_q, state_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;
  logic             mem_state;

  function automatic logic is_legal(input logic [OP_W-1:0] o);
    return (o == OP_R) || (o == OP_LW) || (o == OP_SW) ||
           (o == OP_BEQ) || (o == OP_ADDI) || (o == OP_ORI);
  endfunction

  assign mem_state = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    case (state_q)
      S_FETCH:  if (mem_ready_i) state_d = S_DECODE;
      S_DECODE: begin
        op_d = op_i;
        if ((op_i == OP_R) || (op_i == OP_ADDI) || (op_i == OP_ORI)) state_d = S_EXEC;
        else if ((op_i == OP_LW) || (op_i == OP_SW))                  state_d = S_ADDR;
        else if (op_i == OP_BEQ)                                        state_d = S_BRANCH;
        else if (TRAP_ILLEGAL != 0)                                     state_d = S_HALT;
        else                                                            state_d = S_FETCH;
      end
      S_EXEC:   state_d = S_WB;
      S_ADDR:   state_d = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: if (mem_ready_i) state_d = S_WB;
      S_MEM_WR: if (mem_ready_i) state_d = S_FETCH;
      S_WB:     state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase

    // A ready in the final allowed cycle still counts as success.
    if (mem_state && !mem_ready_i) begin
      if (TO_EN && (cnt_q == CNT_LAST)) begin
        state_d = S_HALT;
        fault_d = 1'b1;
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  // Everything is forced low while reset is held so an abandoned instruction leaves no side effects.
  always_comb begin
    mem_req_o    = 1'b0;
    MemToWrite_o = 1'b0;
    MemToReg_o   = 1'b0;
    RegWrite_o   = 1'b0;
    ALUOp_o      = ALU_ADD;
    alu_src_o    = 1'b0;
    reg_dst_o    = 1'b0;
    ir_write_o   = 1'b0;
    pc_write_o   = 1'b0;
    pc_branch_o  = 1'b0;
    instr_done_o = 1'b0;
    illegal_op_o = 1'b0;
    halted_o     = 1'b0;
    fault_o      = 1'b0;
    if (rst_n_i) begin
      fault_o = fault_q;
      case (state_q)
        S_FETCH: begin
          mem_req_o  = 1'b1;
          ir_write_o = mem_ready_i;
          pc_write_o = mem_ready_i;
        end
        S_DECODE: illegal_op_o = !is_legal(op_i);
        S_EXEC: begin
          if (op_q == OP_R) begin
            ALUOp_o   = ALU_FUNCT;
            alu_src_o = 1'b0;
          end else if (op_q == OP_ORI) begin
            ALUOp_o   = ALU_OR;
            alu_src_o = 1'b1;
          end else begin
            ALUOp_o   = ALU_ADD;
            alu_src_o = 1'b1;
          end
        end
        S_ADDR: begin
          ALUOp_o   = ALU_ADD;
          alu_src_o = 1'b1;
        end
        S_MEM_RD: mem_req_o = 1'b1;
        S_MEM_WR: begin
          mem_req_o    = 1'b1;
          MemToWrite_o = 1'b1;
          instr_done_o = mem_ready_i;
        end
        S_WB: begin
          RegWrite_o   = 1'b1;
          instr_done_o = 1'b1;
          MemToReg_o   = (op_q == OP_LW);
          reg_dst_o    = (op_q == OP_R);
        end
        S_BRANCH: begin
          ALUOp_o      = ALU_SUB;
          instr_done_o = 1'b1;
          pc_branch_o  = zero_i;
        end
        S_HALT:  halted_o = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_unidad_de_control_multiciclo.sv
// Directed bench for the multicycle control unit: one instance traps illegal opcodes,
// the other returns to fetch; both share stimulus and are checked every cycle.
module tb_unidad_de_control_multiciclo;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BAD = 6'b111111;

  localparam logic [15:0] REQ   = 16'h8000;
  localparam logic [15:0] MW    = 16'h4000;
  localparam logic [15:0] MTR   = 16'h2000;
  localparam logic [15:0] RW    = 16'h1000;
  localparam logic [15:0] A_SUB = 16'h0200;
  localparam logic [15:0] A_FN  = 16'h0400;
  localparam logic [15:0] SRC   = 16'h0100;
  localparam logic [15:0] DST   = 16'h0080;
  localparam logic [15:0] IRW   = 16'h0040;
  localparam logic [15:0] PCW   = 16'h0020;
  localparam logic [15:0] BR    = 16'h0010;
  localparam logic [15:0] DONE  = 16'h0008;
  localparam logic [15:0] ILL   = 16'h0004;
  localparam logic [15:0] HLT   = 16'h0002;
  localparam logic [15:0] FLT   = 16'h0001;
  localparam logic [15:0] FETCH_OK = REQ | IRW | PCW;

  logic       clk = 1'b0;
  logic       rstN;
  logic [5:0] op;
  logic       zero;
  logic       memReady;

  logic       req0, mw0, mtr0, rw0, src0, dst0, irw0, pcw0, br0, done0, ill0, hlt0, flt0;
  logic [2:0] alu0;
  logic       req1, mw1, mtr1, rw1, src1, dst1, irw1, pcw1, br1, done1, ill1, hlt1, flt1;
  logic [2:0] alu1;
  logic [15:0] obs0, obs1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  unidad_de_control_multiciclo #(.TRAP_ILLEGAL(1)) dutTrap (
    .clk_i(clk), .rst_n_i(rstN), .op_i(op), .zero_i(zero), .mem_ready_i(memReady),
    .mem_req_o(req0), .MemToWrite_o(mw0), .MemToReg_o(mtr0), .RegWrite_o(rw0),
    .ALUOp_o(alu0), .alu_src_o(src0), .reg_dst_o(dst0), .ir_write_o(irw0),
    .pc_write_o(pcw0), .pc_branch_o(br0), .instr_done_o(done0), .illegal_op_o(ill0),
    .halted_o(hlt0), .fault_o(flt0)
  );

  unidad_de_control_multiciclo #(.TRAP_ILLEGAL(0)) dutSkip (
    .clk_i(clk), .rst_n_i(rstN), .op_i(op), .zero_i(zero), .mem_ready_i(memReady),
    .mem_req_o(req1), .MemToWrite_o(mw1), .MemToReg_o(mtr1), .RegWrite_o(rw1),
    .ALUOp_o(alu1), .alu_src_o(src1), .reg_dst_o(dst1), .ir_write_o(irw1),
    .pc_write_o(pcw1), .pc_branch_o(br1), .instr_done_o(done1), .illegal_op_o(ill1),
    .halted_o(hlt1), .fault_o(flt1)
  );

  assign obs0 = {req0, mw0, mtr0, rw0, alu0, src0, dst0, irw0, pcw0, br0, done0, ill0, hlt0, flt0};
  assign obs1 = {req1, mw1, mtr1, rw1, alu1, src1, dst1, irw1, pcw1, br1, done1, ill1, hlt1, flt1};

  task automatic applyStimulus(input logic r, input logic [5:0] o, input logic mr, input logic z);
    rstN     = r;
    op       = o;
    memReady = mr;
    zero     = z;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] e0, input logic [15:0] e1);
    checks++;
    assert (obs0 === e0) else begin
      errors++;
      $error("FAIL %s trap observed=%h expected=%h", tag, obs0, e0);
    end
    checks++;
    assert (obs1 === e1) else begin
      errors++;
      $error("FAIL %s skip observed=%h expected=%h", tag, obs1, e1);
    end
    @(negedge clk);
  endtask

  task automatic step(input string tag, input logic r, input logic [5:0] o, input logic mr,
                      input logic z, input logic [15:0] e0, input logic [15:0] e1);
    applyStimulus(r, o, mr, z);
    checkOutput(tag, e0, e1);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) step("reset", 1'b0, OP_R, 1'b1, 1'b0, 16'h0, 16'h0);

    step("r_fetch",  1'b1, OP_R, 1'b1, 1'b0, FETCH_OK, FETCH_OK);
    step("r_decode", 1'b1, OP_R, 1'b1, 1'b0, 16'h0, 16'h0);
    step("r_exec",   1'b1, OP_R, 1'b1, 1'b0, A_FN, A_FN);
    step("r_wb",     1'b1, OP_R, 1'b1, 1'b0, RW | DST | DONE, RW | DST | DONE);

    step("lw_fetch",  1'b1, OP_LW, 1'b1, 1'b0, FETCH_OK, FETCH_OK);
    step("lw_decode", 1'b1, OP_LW, 1'b1, 1'b0, 16'h0, 16'h0);
    step("lw_addr",   1'b1, OP_LW, 1'b1, 1'b0, SRC, SRC);
    step("lw_wait1",  1'b1, OP_LW, 1'b0, 1'b0, REQ, REQ);
    step("lw_wait2",  1'b1, OP_LW, 1'b0, 1'b0, REQ, REQ);
    step("lw_rd",     1'b1, OP_LW, 1'b1, 1'b0, REQ, REQ);
    step("lw_wb",     1'b1, OP_LW, 1'b1, 1'b0, RW | MTR | DONE, RW | MTR | DONE);

    step("sw_fetch",  1'b1, OP_SW, 1'b1, 1'b0, FETCH_OK, FETCH_OK);
    step("sw_decode", 1'b1, OP_SW, 1'b1, 1'b0, 16'h0, 16'h0);
    step("sw_addr",   1'b1, OP_SW, 1'b1, 1'b0, SRC, SRC);
    step("sw_wr",     1'b1, OP_SW, 1'b1, 1'b0, REQ | MW | DONE, REQ | MW | DONE);
    step("sw_next",   1'b1, OP_SW, 1'b0, 1'b0, REQ, REQ);

    step("beq1_fetch",  1'b1, OP_BEQ, 1'b1, 1'b1, FETCH_OK, FETCH_OK);
    step("beq1_decode", 1'b1, OP_BEQ, 1'b1, 1'b1, 16'h0, 16'h0);
    step("beq1_branch", 1'b1, OP_BEQ, 1'b1, 1'b1, A_SUB | DONE | BR, A_SUB | DONE | BR);
    step("beq0_fetch",  1'b1, OP_BEQ, 1'b1, 1'b0, FETCH_OK, FETCH_OK);
    step("beq0_decode", 1'b1, OP_BEQ, 1'b1, 1'b0, 16'h0, 16'h0);
    step("beq0_branch", 1'b1, OP_BEQ, 1'b1, 1'b0, A_SUB | DONE, A_SUB | DONE);

    step("ill_fetch",  1'b1, OP_BAD, 1'b1, 1'b0, FETCH_OK, FETCH_OK);
    step("ill_decode", 1'b1, OP_BAD, 1'b1, 1'b0, ILL, ILL);
    step("ill_after",  1'b1, OP_BAD, 1'b0, 1'b0, HLT, REQ);
    step("ill_hold",   1'b1, OP_BAD, 1'b1, 1'b0, HLT, FETCH_OK);
    step("rst_clear",  1'b0, OP_R,   1'b0, 1'b0, 16'h0, 16'h0);

    // Fifteen unanswered fetch cycles exhaust the budget.
    for (int i = 0; i < 15; i++) step("to_wait", 1'b1, OP_R, 1'b0, 1'b0, REQ, REQ);
    step("to_halt",  1'b1, OP_R, 1'b0, 1'b0, HLT | FLT, HLT | FLT);
    step("to_hold",  1'b1, OP_R, 1'b1, 1'b0, HLT | FLT, HLT | FLT);
    step("to_rst",   1'b0, OP_R, 1'b1, 1'b0, 16'h0, 16'h0);

    for (int i = 0; i < 14; i++) step("rdy_wait", 1'b1, OP_R, 1'b0, 1'b0, REQ, REQ);
    step("rdy_last",   1'b1, OP_R, 1'b1, 1'b0, FETCH_OK, FETCH_OK);
    step("rdy_decode", 1'b1, OP_R, 1'b0, 1'b0, 16'h0, 16'h0);
    step("rdy_exec",   1'b1, OP_R, 1'b0, 1'b0, A_FN, A_FN);
    step("mid_rst",    1'b0, OP_R, 1'b1, 1'b0, 16'h0, 16'h0);
    step("post_fetch", 1'b1, OP_R, 1'b1, 1'b0, FETCH_OK, FETCH_OK);
    step("post_dec",   1'b1, OP_R, 1'b1, 1'b0, 16'h0, 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/unidad_de_control_multiciclo.md
Name: unidad_de_control_multiciclo

Overview:
- Multicycle successor to the single-cycle control unit.
- FSM sequences fetch/decode/execute/memory/writeback for the MIPS-subset datapath, one instruction at a time.
- Memory accesses use a req/ready handshake with a configurable timeout.
- Drives the same control set as before (MemToReg, MemToWrite, ALUOp, RegWrite) plus PC/IR/branch/mux strobes and status flags.

Parameters:
- OP_W, 6, opcode width.
- ALUOP_W, 3, ALUOp width. Encodings: 000 add, 001 sub, 010 use funct, 011 or.
- MEM_TIMEOUT, 15, maximum wait cycles for mem_ready; 0 disables the timeout.
- TRAP_ILLEGAL, 1. 1: an illegal opcode halts. 0: illegal opcode pulses illegal_op and the FSM returns to FETCH.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- op  in  OP_W  opcode field from the instruction register; valid from DECODE onward.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the access in the current cycle.
- mem_req  out  1  memory access request.
- MemToWrite  out  1  memory write enable; valid only together with mem_req.
- MemToReg  out  1  writeback source: 1 = memory, 0 = ALU.
- RegWrite  out  1  register file write enable.
- ALUOp  out  ALUOP_W  ALU operation.
- alu_src  out  1  ALU B operand: 1 = immediate, 0 = register.
- reg_dst  out  1  destination register: 1 = rd, 0 = rt.
- ir_write  out  1  load the instruction register.
- pc_write  out  1  PC <= PC+4.
- pc_branch  out  1  PC <= branch target.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- illegal_op  out  1  one-cycle pulse in DECODE for an unknown opcode.
- halted  out  1  FSM is in HALT.
- fault  out  1  sticky memory-timeout flag; cleared only by reset.

Behaviour:
- Opcodes: R 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, ORI 001101. Every other opcode is illegal.
- Outputs are Moore, decoded from the state register and op_q (opcode latched in DECODE).
- During any cycle with rst_n low, all outputs are 0, fault is cleared, the counter is cleared, and the next state is FETCH.
- FETCH: mem_req=1.
  - On mem_ready: ir_write=1, pc_write=1 in that same cycle, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: 1 cycle; op_q<=op.
  - R, ADDI, ORI -> EXEC.
  - LW, SW -> ADDR.
  - BEQ -> BRANCH.
  - Illegal: illegal_op=1, then HALT if TRAP_ILLEGAL=1, else FETCH with instr_done=0.
- EXEC: 1 cycle, then WB.
  - R: ALUOp=010, alu_src=0.
  - ADDI: ALUOp=000, alu_src=1.
  - ORI: ALUOp=011, alu_src=1.
- ADDR: ALUOp=000, alu_src=1. LW -> MEM_RD; SW -> MEM_WR.
- MEM_RD: mem_req=1, MemToWrite=0. Go to WB on mem_ready.
- MEM_WR: mem_req=1, MemToWrite=1. On mem_ready: instr_done=1, then go to FETCH.
- WB: RegWrite=1, instr_done=1, then go to FETCH.
  - MemToReg=1 for LW, else 0.
  - reg_dst=1 for R, else 0.
- BRANCH: ALUOp=001, alu_src=0, instr_done=1, then go to FETCH.
  - pc_branch=zero in the same cycle.
- HALT: all strobes 0, halted=1. HALT is terminal until reset.
- Zero-wait latency (cycles from FETCH entry to instr_done):
  - BEQ 3.
  - R, ADDI, ORI, SW 4.
  - LW 5.
- Each extra cycle with mem_ready low adds 1 cycle.
- Wait counter:
  - Width clog2(MEM_TIMEOUT+1).
  - Cleared on entry to FETCH, MEM_RD and MEM_WR.
  - Increments each cycle mem_req=1 and mem_ready=0.
  - If it reaches MEM_TIMEOUT while mem_ready=0, next state is HALT and fault<=1. No strobes are issued for that access.
- Simultaneous events: mem_ready in the same cycle the counter hits MEM_TIMEOUT counts as success; ready wins.
- Reset asserted mid-instruction: abandon the instruction with no partial RegWrite/MemToWrite in that cycle; resume at FETCH.
- mem_ready is ignored outside the memory states.

Test Plan:
- Reset low 3 cycles, then R-type op=000000 with mem_ready tied 1 -> all outputs 0 during reset. ALUOp=010 in cycle 3. RegWrite=1, reg_dst=1, instr_done=1 in cycle 4. pc_write pulses exactly once.
- LW op=100011, mem_ready held low 2 cycles in MEM_RD -> instr_done in cycle 7. MemToReg=1 and RegWrite=1 only in WB. MemToWrite never 1.
- SW op=101011 -> MemToWrite=1 with mem_req=1 in cycle 4. RegWrite stays 0. Next cycle is FETCH.
- BEQ op=000100: with zero=1, pc_branch=1 in cycle 3. With zero=0, pc_branch=0. ALUOp=001 in both cases.
- Illegal op=111111:
  - TRAP_ILLEGAL=1 -> illegal_op pulse, then halted=1 stays set.
  - TRAP_ILLEGAL=0 -> next cycle is FETCH, no RegWrite.
- MEM_TIMEOUT=15, mem_ready held 0 in FETCH -> after 15 waiting cycles halted=1, fault=1. Repeat with mem_ready=1 on the 15th cycle -> proceeds to DECODE, fault=0. Assert rst_n=0 -> fault clears.
